// File: rtl/wb_burst_sram.sv
// rtl/wb_burst_sram.sv - Wishbone B4 burst-capable SRAM slave with a native side port
//
// Ports:
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   wishbone_*          B4 slave: classic cycles and incrementing bursts
//                       (linear, wrap-4/8/16), byte-lane writes, err on out-of-range
//   sram_adr/dat_w/we   side-port full-word write, committed at the clock edge
//   sram_dat_r          side-port read data, one cycle after sram_adr
module wb_burst_sram #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADR_WIDTH  = 30,
    parameter  int DEPTH_LOG2 = 6,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADR_WIDTH-1:0]  wishbone_adr,
    input  logic [DATA_WIDTH-1:0] wishbone_dat_w,
    output logic [DATA_WIDTH-1:0] wishbone_dat_r,
    input  logic                  wishbone_cyc,
    input  logic                  wishbone_stb,
    input  logic                  wishbone_we,
    input  logic [SEL_WIDTH-1:0]  wishbone_sel,
    input  logic [2:0]            wishbone_cti,
    input  logic [1:0]            wishbone_bte,
    output logic                  wishbone_ack,
    output logic                  wishbone_err,
    input  logic [DEPTH_LOG2-1:0] sram_adr,
    output logic [DATA_WIDTH-1:0] sram_dat_r,
    input  logic [DATA_WIDTH-1:0] sram_dat_w,
    input  logic                  sram_we
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST, S_ERR} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state, state_next;
    logic [DEPTH_LOG2-1:0] ptr, ptr_next, ptr_step, rd_idx, adr_idx, wrap_mask;
    logic                  in_range, req, wb_wr, side_wr;

    assign adr_idx  = wishbone_adr[DEPTH_LOG2-1:0];
    assign in_range = (wishbone_adr >> DEPTH_LOG2) == '0;
    assign req      = wishbone_cyc & wishbone_stb;

    // Wrap-N bursts only advance the low log2(N) pointer bits; linear is a
    // wrap over the whole memory, so it shares the same masked increment.
    always_comb begin
        case (wishbone_bte)
            2'b01:   wrap_mask = DEPTH_LOG2'(3);
            2'b10:   wrap_mask = DEPTH_LOG2'(7);
            2'b11:   wrap_mask = DEPTH_LOG2'(15);
            default: wrap_mask = '1;
        endcase
    end

    assign ptr_step = (ptr & ~wrap_mask) | ((ptr + DEPTH_LOG2'(1)) & wrap_mask);

    // rd_idx selects the word loaded into wishbone_dat_r at the next edge, so
    // burst data is always prefetched one beat ahead of its ack.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        rd_idx       = ptr;
        wishbone_ack = 1'b0;
        wishbone_err = 1'b0;
        case (state)
            S_IDLE: begin
                rd_idx = adr_idx;
                if (req) begin
                    if (!in_range) begin
                        state_next = S_ERR;
                    end else if (wishbone_cti == 3'b010) begin
                        state_next = S_BURST;
                        ptr_next   = adr_idx;
                    end else begin
                        state_next = S_CLASSIC;
                    end
                end
            end
            S_CLASSIC: begin
                wishbone_ack = req;
                state_next   = S_IDLE;
            end
            S_BURST: begin
                wishbone_ack = req & in_range & (adr_idx == ptr);
                if (!wishbone_cyc) begin
                    state_next = S_IDLE;
                end else if (wishbone_ack) begin
                    ptr_next = ptr_step;
                    rd_idx   = ptr_step;
                    if (wishbone_cti == 3'b111) state_next = S_IDLE;
                end else if (wishbone_stb) begin
                    // Master jumped elsewhere: re-decode as a fresh request.
                    state_next = in_range ? S_IDLE : S_ERR;
                end
            end
            S_ERR: begin
                wishbone_err = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Reset kills the beat in flight so nothing commits in the reset cycle.
        if (reset) begin
            wishbone_ack = 1'b0;
            wishbone_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            ptr            <= '0;
            wishbone_dat_r <= '0;
            sram_dat_r     <= '0;
        end else begin
            state          <= state_next;
            ptr            <= ptr_next;
            wishbone_dat_r <= mem[rd_idx];
            sram_dat_r     <= mem[sram_adr];
        end
    end

    // A Wishbone write touching any lane of the side port's word wins the
    // whole word; the side write is dropped rather than merged.
    assign wb_wr   = wishbone_ack & wishbone_we;
    assign side_wr = sram_we & ~(wb_wr & (|wishbone_sel) & (adr_idx == sram_adr));

    always_ff @(posedge clk) begin
        if (side_wr) mem[sram_adr] <= sram_dat_w;
        if (wb_wr) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (wishbone_sel[i]) mem[adr_idx][8*i +: 8] <= wishbone_dat_w[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_burst_sram.sv
// tb/tb_wb_burst_sram.sv - directed self-checking bench for wb_burst_sram
module tb_wb_burst_sram;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] wishbone_adr = '0;
    logic [31:0] wishbone_dat_w = '0;
    logic [31:0] wishbone_dat_r;
    logic        wishbone_cyc = 1'b0;
    logic        wishbone_stb = 1'b0;
    logic        wishbone_we = 1'b0;
    logic [3:0]  wishbone_sel = '0;
    logic [2:0]  wishbone_cti = '0;
    logic [1:0]  wishbone_bte = '0;
    logic        wishbone_ack;
    logic        wishbone_err;
    logic [5:0]  sram_adr = '0;
    logic [31:0] sram_dat_r;
    logic [31:0] sram_dat_w = '0;
    logic        sram_we = 1'b0;

    wb_burst_sram #(.DATA_WIDTH(32), .ADR_WIDTH(30), .DEPTH_LOG2(6)) dut (
        .clk(clk), .reset(reset),
        .wishbone_adr(wishbone_adr), .wishbone_dat_w(wishbone_dat_w),
        .wishbone_dat_r(wishbone_dat_r), .wishbone_cyc(wishbone_cyc),
        .wishbone_stb(wishbone_stb), .wishbone_we(wishbone_we),
        .wishbone_sel(wishbone_sel), .wishbone_cti(wishbone_cti),
        .wishbone_bte(wishbone_bte), .wishbone_ack(wishbone_ack),
        .wishbone_err(wishbone_err), .sram_adr(sram_adr),
        .sram_dat_r(sram_dat_r), .sram_dat_w(sram_dat_w), .sram_we(sram_we)
    );

    always #5 clk = ~clk;

    bit   [31:0] model [DEPTH];
    int          checks = 0;
    int          passed = 0;
    logic        chk_en = 1'b0;
    logic        exp_ack = 1'b0, exp_err = 1'b0, chk_dat = 1'b0;
    logic [31:0] exp_dat = '0, exp_side = '0, last_rd = '0;
    logic        pend_wb = 1'b0;
    logic [5:0]  pend_adr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", {31'b0, wishbone_ack}, {31'b0, exp_ack});
            check("err", {31'b0, wishbone_err}, {31'b0, exp_err});
            check("sram_dat_r", sram_dat_r, exp_side);
            if (chk_dat) check("wb_dat_r", wishbone_dat_r, exp_dat);
            if (wishbone_ack && !wishbone_we) last_rd = wishbone_dat_r;
        end
    end

    // One clock: side port returns the pre-edge word; committed writes then
    // land in the model, Wishbone first, side write dropped on a collision.
    task automatic tick();
        @(posedge clk);
        exp_side = reset ? 32'h0 : model[sram_adr];
        if (pend_wb) begin
            for (int i = 0; i < 4; i++)
                if (wishbone_sel[i]) model[pend_adr][8*i +: 8] = wishbone_dat_w[8*i +: 8];
        end
        if (sram_we && !(pend_wb && wishbone_sel != 4'b0 && pend_adr == sram_adr))
            model[sram_adr] = sram_dat_w;
        pend_wb = 1'b0;
        #1;
    endtask

    task automatic expect_cycle(input logic a, input logic e, input logic cd, input logic [31:0] d);
        exp_ack = a; exp_err = e; chk_dat = cd; exp_dat = d;
    endtask

    task automatic wb_idle();
        wishbone_cyc = 1'b0; wishbone_stb = 1'b0; wishbone_we = 1'b0; wishbone_cti = 3'b000;
    endtask

    task automatic side_write(input logic [5:0] a, input logic [31:0] d);
        sram_adr = a; sram_dat_w = d; sram_we = 1'b1;
        expect_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        sram_we = 1'b0;
    endtask

    task automatic side_check(input string name, input logic [5:0] a, input logic [31:0] lit);
        sram_adr = a; sram_we = 1'b0;
        expect_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check(name, sram_dat_r, lit);
    endtask

    // side_cyc: 0 none, 1 side write alongside the request cycle, 2 alongside the ack cycle
    task automatic classic(input logic [29:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] sel, input int side_cyc,
                           input logic [5:0] s_adr, input logic [31:0] s_dat);
        logic        inr;
        logic [31:0] snap;
        inr  = (a < 30'(DEPTH));
        snap = model[a[5:0]];
        wishbone_cyc = 1'b1; wishbone_stb = 1'b1; wishbone_we = we; wishbone_adr = a;
        wishbone_dat_w = d; wishbone_sel = sel; wishbone_cti = 3'b000; wishbone_bte = 2'b00;
        sram_adr = s_adr; sram_dat_w = s_dat; sram_we = (side_cyc == 1);
        expect_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        sram_we = (side_cyc == 2);
        expect_cycle(inr, !inr, inr && !we, snap);
        pend_wb = inr && we; pend_adr = a[5:0];
        tick();
        sram_we = 1'b0; wb_idle();
        expect_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    function automatic int burst_addr(input int start, input logic [1:0] bte, input int k);
        int n;
        case (bte)
            2'b00:   n = DEPTH;
            2'b01:   n = 4;
            2'b10:   n = 8;
            default: n = 16;
        endcase
        return (start / n) * n + (start % n + k) % n;
    endfunction

    task automatic burst(input int start, input logic [1:0] bte, input int n, input logic we,
                         input logic [31:0] dbase, input int gap_after, input int gap_len,
                         input int reset_at);
        int a;
        wishbone_cyc = 1'b1; wishbone_stb = 1'b1; wishbone_we = we; wishbone_adr = 30'(start);
        wishbone_dat_w = dbase; wishbone_sel = 4'hf; wishbone_cti = 3'b010; wishbone_bte = bte;
        expect_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < n; k++) begin
            a = burst_addr(start, bte, k);
            wishbone_stb = 1'b1; wishbone_adr = 30'(a); wishbone_dat_w = dbase + 32'(k);
            wishbone_cti = (k == n - 1) ? 3'b111 : 3'b010;
            if (k == reset_at) begin
                reset = 1'b1;
                expect_cycle(1'b0, 1'b0, 1'b0, 32'h0);
                tick();
                check("rst_mid_dat_r", wishbone_dat_r, 32'h0);
                check("rst_mid_sram_dat_r", sram_dat_r, 32'h0);
                reset = 1'b0; wb_idle();
                tick();
                return;
            end
            expect_cycle(1'b1, 1'b0, !we, model[a]);
            pend_wb = we; pend_adr = 6'(a);
            tick();
            if (k == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    wishbone_stb = 1'b0; wishbone_adr = '0;
                    expect_cycle(1'b0, 1'b0, 1'b0, 32'h0);
                    tick();
                end
            end
        end
        wishbone_stb = 1'b0; wishbone_cti = 3'b000;
        expect_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        wb_idle();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        wb_idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_ack", {31'b0, wishbone_ack}, 32'h0);
        check("rst_err", {31'b0, wishbone_err}, 32'h0);
        check("rst_dat_r", wishbone_dat_r, 32'h0);
        check("rst_sram_dat_r", sram_dat_r, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) side_write(6'(i), 32'hC0DE_0000 + 32'(i));
        sram_adr = '0;
        tick();
        chk_en = 1'b1;

        side_write(6'd5, 32'hDEAD_BEEF);
        classic(30'd5, 1'b0, 32'h0, 4'hf, 0, 6'd0, 32'h0);
        check("classic_rd_lit", last_rd, 32'hDEAD_BEEF);

        side_write(6'd3, 32'hAAAA_AAAA);
        classic(30'd3, 1'b1, 32'h1122_3344, 4'b0101, 0, 6'd0, 32'h0);
        side_check("sel_lanes_3", 6'd3, 32'hAA22_AA44);

        burst(62, 2'b00, 4, 1'b0, 32'h0, -1, 0, -1);
        check("linear_last_rd", last_rd, 32'hC0DE_0001);

        burst(6, 2'b01, 4, 1'b1, 32'h1, -1, 0, -1);
        side_check("wrap4_6", 6'd6, 32'h1);
        side_check("wrap4_7", 6'd7, 32'h2);
        side_check("wrap4_4", 6'd4, 32'h3);
        side_check("wrap4_5", 6'd5, 32'h4);
        side_check("wrap4_8_untouched", 6'd8, 32'hC0DE_0008);

        burst(21, 2'b10, 8, 1'b0, 32'h0, 1, 2, -1);
        check("wrap8_last_rd", last_rd, 32'hC0DE_0014);

        classic(30'd64, 1'b1, 32'h1234_5678, 4'hf, 0, 6'd0, 32'h0);
        side_check("err_no_write_0", 6'd0, 32'hC0DE_0000);

        classic(30'd9, 1'b1, 32'h1, 4'hf, 2, 6'd9, 32'h2);
        side_check("collide_9", 6'd9, 32'h1);

        classic(30'd11, 1'b1, 32'h0B0B, 4'hf, 2, 6'd12, 32'h0C0C);
        side_check("both_11", 6'd11, 32'h0B0B);
        side_check("both_12", 6'd12, 32'h0C0C);

        classic(30'd5, 1'b0, 32'h0, 4'hf, 1, 6'd5, 32'h55);
        check("rd_old_on_side_wr", last_rd, 32'h4);
        side_check("side_new_5", 6'd5, 32'h55);

        classic(30'd13, 1'b1, 32'hFFFF_FFFF, 4'b0000, 0, 6'd0, 32'h0);
        side_check("sel0_13", 6'd13, 32'hC0DE_000D);

        burst(16, 2'b00, 8, 1'b1, 32'h100, -1, 0, 1);
        side_check("rst_burst_16", 6'd16, 32'h100);
        side_check("rst_burst_17", 6'd17, 32'hC0DE_0011);
        side_check("rst_burst_18", 6'd18, 32'hC0DE_0012);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_burst_sram.md
Name: wb_burst_sram

Overview:
Parametrised Wishbone B4 slave wrapping a single-clock word-addressed SRAM, with a second native side port for direct host/bench access. Supports classic cycles and registered-feedback incrementing bursts (linear, wrap-4/8/16) at one beat per clock, with byte-lane writes. Successor to the fixed 32-bit/64-word SRAM slave in the burst benchmark DUT; sits behind the interconnect as a burst-capable memory target.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8
ADR_WIDTH, 30, Wishbone word-address width
DEPTH_LOG2, 6, log2 of memory depth in words; DEPTH = 2**DEPTH_LOG2
SEL_WIDTH, DATA_WIDTH/8, byte-select width (derived, not overridden)

Ports:
clk  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
wishbone_adr  in  ADR_WIDTH  word address
wishbone_dat_w  in  DATA_WIDTH  write data
wishbone_dat_r  out  DATA_WIDTH  read data, valid while wishbone_ack=1
wishbone_cyc  in  1  cycle valid
wishbone_stb  in  1  strobe
wishbone_we  in  1  write enable
wishbone_sel  in  SEL_WIDTH  byte lanes
wishbone_cti  in  3  000 classic, 010 incrementing burst, 111 end-of-burst; others treated as classic
wishbone_bte  in  2  00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
wishbone_ack  out  1  beat acknowledge
wishbone_err  out  1  out-of-range error
sram_adr  in  DEPTH_LOG2  side-port word address
sram_dat_r  out  DATA_WIDTH  side-port read data, 1-cycle latency
sram_dat_w  in  DATA_WIDTH  side-port write data
sram_we  in  1  side-port full-word write

Behaviour:
- Reset: wishbone_ack=0, wishbone_err=0, wishbone_dat_r=0, sram_dat_r=0, FSM=IDLE, burst pointer=0. Memory contents not cleared. Reset mid-burst aborts immediately; no write is committed in the reset cycle.
- In range: wishbone_adr[ADR_WIDTH-1:DEPTH_LOG2]==0.
- A beat completes on a rising edge where cyc&stb&ack. Writes commit at that edge, per byte lane of sel; sel=0 is acked with no write.
- IDLE: on cyc&stb. Out of range -> ERR. cti==010 -> BURST, ptr=adr. Otherwise -> CLASSIC. Read data for adr is registered in the same edge.
- CLASSIC: ack=1 for exactly one cycle, dat_r=mem[adr]. Then IDLE. Each classic access costs 2 cycles.
- BURST: ack = cyc&stb&(adr[DEPTH_LOG2-1:0]==ptr)&in-range (gated combinationally from registered ready). dat_r=mem[ptr], prefetched one cycle earlier.
  - On a completed beat, ptr advances. Linear: ptr+1, wrapping mod DEPTH. Wrap-N: low log2(N) bits increment modulo N, upper bits held.
  - If the completed beat had cti==111 -> IDLE, ack low next cycle.
  - stb low: hold ptr, ack=0, stay in BURST.
  - cyc low: -> IDLE.
  - stb high with adr!=ptr (master restarted): no ack; treated as a fresh IDLE request next cycle.
- ERR: err=1 for one cycle, ack=0, no write, then IDLE. The same applies if a linear burst presents an out-of-range adr.
- Throughput: first beat 1 cycle after stb; subsequent beats one per cycle.
- Side port: sram_dat_r <= mem[sram_adr] every cycle. If sram_we=1, the write commits at that edge.
- Side-port read of an address being written returns old data.
- Simultaneous Wishbone write and side write to the same word: Wishbone write wins; side write dropped. Different words: both commit.
- A Wishbone read concurrent with a side write to the same word returns old data.

Test Plan:
- Reset, then side-write mem[5]=0xDEADBEEF; classic read adr=5 -> ack high exactly 1 cycle at cycle 2 after stb, dat_r=0xDEADBEEF, err=0.
- Classic write adr=3, dat=0x11223344, sel=0b0101 over pre-filled 0xAAAAAAAA -> side read of 3 returns 0xAA22AA44.
- Linear burst read adr=62, cti 010,010,010,111 -> 4 consecutive acks at addresses 62,63,0,1 (wrap mod 64); IDLE after the 111 beat.
- Wrap-4 burst write starting adr=6, 4 beats with data 1..4 -> mem[6]=1, mem[7]=2, mem[4]=3, mem[5]=4; mem[8] unchanged.
- Burst with stb dropped 2 cycles after beat 2 -> no acks during gap, ptr held; beat 3 acks in the first cycle stb returns with the correct adr. Classic access to adr=64 -> err=1 for 1 cycle, no ack, memory unchanged.
- Same-cycle Wishbone write 0x1 and side write 0x2 to word 9 -> mem[9]=0x1. Assert reset during beat 2 of an 8-beat burst -> ack=0 next cycle, beats 3+ not written.
